// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
// Scoreboard-based hazard detection and operand forwarding for the in-order
// pipeline. The scoreboard tracks one in-flight write per stage after ID
// (entry 0 = EX ... entry DEPTH-1 = WB). For each source operand of the
// instruction in ID the unit finds the youngest in-flight writer. It then
// either forwards that writer's result or stalls until the result exists.
// A saturating counter records the number of stalled cycles.
module hazard_fwd_unit #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int FWD_EN     = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         id_valid,
  input  logic [AW-1:0]                id_rs1_addr,
  input  logic                         id_rs1_used,
  input  logic [AW-1:0]                id_rs2_addr,
  input  logic                         id_rs2_used,
  input  logic [AW-1:0]                id_rd_addr,
  input  logic                         id_rf_wen,
  input  logic                         id_is_load,
  input  logic                         flush,
  input  logic [XLEN-1:0]              rf_rs1_data,
  input  logic [XLEN-1:0]              rf_rs2_data,
  input  logic [DEPTH*XLEN-1:0]        stage_data,
  output logic                         stall,
  output logic                         issue,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_sel_rs1,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_sel_rs2,
  output logic [XLEN-1:0]              fw_rs1_data,
  output logic [XLEN-1:0]              fw_rs2_data,
  output logic [31:0]                  stall_cnt
);

  localparam int SW = $clog2(DEPTH + 1);

  // Scoreboard: one record per stage after ID, index 0 is the youngest.
  logic [DEPTH-1:0]         sb_valid_q, sb_valid_d;
  logic [DEPTH-1:0]         sb_wen_q,   sb_wen_d;
  logic [DEPTH-1:0]         sb_load_q,  sb_load_d;
  logic [DEPTH-1:0][AW-1:0] sb_rd_q,    sb_rd_d;

  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Per-operand lookup results.
  logic          rs1_hit, rs1_avail;
  logic          rs2_hit, rs2_avail;
  logic [SW-1:0] rs1_idx, rs2_idx;
  logic          stall_rs1, stall_rs2;
  logic          fwd_ok;

  // Forwarding can be disabled at build time; every match then becomes a stall.
  assign fwd_ok = (FWD_EN != 0);

  // Youngest-writer lookup. The loop walks from the oldest entry to the
  // youngest, so the last assignment comes from the youngest match. x0 never
  // matches because it is hardwired to zero and is never a real dependency.
  function automatic logic [SW+1:0] lookup(input logic [AW-1:0] addr,
                                           input logic          used);
    logic          hit;
    logic          avail;
    logic [SW-1:0] idx;
    hit   = 1'b0;
    avail = 1'b0;
    idx   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (sb_valid_q[k] && sb_wen_q[k] && (sb_rd_q[k] == addr) &&
          (addr != '0) && used) begin
        hit   = 1'b1;
        idx   = SW'(k);
        // Load results appear only from LOAD_STAGE onward.
        avail = !sb_load_q[k] || (k >= LOAD_STAGE);
      end
    end
    return {hit, avail, idx};
  endfunction

  // Resolve the dependency of each source operand against the scoreboard.
  always_comb begin
    {rs1_hit, rs1_avail, rs1_idx} = lookup(id_rs1_addr, id_rs1_used);
    {rs2_hit, rs2_avail, rs2_idx} = lookup(id_rs2_addr, id_rs2_used);
  end

  // Stall and issue decisions. A flush kills the ID instruction, so a stall
  // in the same cycle would only hold a dead instruction; flush wins.
  always_comb begin
    stall_rs1 = id_valid && rs1_hit && (!rs1_avail || !fwd_ok);
    stall_rs2 = id_valid && rs2_hit && (!rs2_avail || !fwd_ok);
    stall     = (stall_rs1 || stall_rs2) && !flush && !reset;
    issue     = id_valid && !stall && !flush;
  end

  // Operand selection: select 0 is the register file, k+1 is entry k. The
  // WB entry still forwards because a write in WB is seen by reads next cycle.
  always_comb begin
    fwd_sel_rs1 = '0;
    fwd_sel_rs2 = '0;
    if (!reset && fwd_ok && rs1_hit && rs1_avail) begin
      fwd_sel_rs1 = rs1_idx + SW'(1);
    end
    if (!reset && fwd_ok && rs2_hit && rs2_avail) begin
      fwd_sel_rs2 = rs2_idx + SW'(1);
    end
    fw_rs1_data = rf_rs1_data;
    fw_rs2_data = rf_rs2_data;
    if (fwd_sel_rs1 != '0) begin
      fw_rs1_data = stage_data[int'(rs1_idx)*XLEN +: XLEN];
    end
    if (fwd_sel_rs2 != '0) begin
      fw_rs2_data = stage_data[int'(rs2_idx)*XLEN +: XLEN];
    end
  end

  // Scoreboard advance: the ID instruction enters entry 0 only when it
  // issues. Otherwise a bubble enters. All other entries move one stage older.
  always_comb begin
    sb_valid_d = '0;
    sb_wen_d   = '0;
    sb_load_d  = '0;
    sb_rd_d    = '0;
    sb_valid_d[0] = issue;
    sb_wen_d[0]   = issue && id_rf_wen;
    sb_load_d[0]  = issue && id_is_load;
    sb_rd_d[0]    = issue ? id_rd_addr : '0;
    for (int k = 1; k < DEPTH; k++) begin
      sb_valid_d[k] = sb_valid_q[k-1];
      sb_wen_d[k]   = sb_wen_q[k-1];
      sb_load_d[k]  = sb_load_q[k-1];
      sb_rd_d[k]    = sb_rd_q[k-1];
    end
  end

  // The stall counter saturates instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // State registers. Reset may arrive at any time, including mid-stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_valid_q  <= '0;
      sb_wen_q    <= '0;
      sb_load_q   <= '0;
      sb_rd_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_valid_q  <= sb_valid_d;
      sb_wen_q    <= sb_wen_d;
      sb_load_q   <= sb_load_d;
      sb_rd_q     <= sb_rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
